w0rm_core_alu_writeback: RTL and testbench
==========================================

# w0rm_core_alu_writeback

ALU writeback stage for the W0RM core: sits directly downstream of `W0RM_Core_ALU`, captures each valid ALU result with its destination register and flag-store mask, updates the architectural flag register, and drains results in order to the register-file write port through a 2-entry queue. It absorbs register-file back-pressure, exposes the youngest pending result for operand forwarding, and tells the issue logic when it can accept another result.

## Interface
- `DATA_WIDTH`, 32, width of ALU result and register-file data
- `REG_ADDR_WIDTH`, 4, width of destination register index
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  drop all queued writes and the same-cycle input
- `alu_result_valid`  in  1  ALU result present this cycle
- `alu_result`  in  DATA_WIDTH  ALU result
- `alu_flag_zero`, `alu_flag_negative`, `alu_flag_overflow`, `alu_flag_carry`  in  1 each  ALU flag outputs
- `alu_dest`  in  REG_ADDR_WIDTH  destination register of the result
- `alu_flags_mask`  in  4  flag store mask, bit3=Z, bit2=N, bit1=V, bit0=C
- `wb_ready`  out  1  stage can accept a result this cycle
- `rf_write_en`  out  1  queue head is valid
- `rf_write_addr`  out  REG_ADDR_WIDTH  head destination
- `rf_write_data`  out  DATA_WIDTH  head data
- `rf_write_ready`  in  1  register file accepts the head this cycle
- `flags`  out  4  architectural flags {Z,N,V,C}
- `fwd_valid`  out  1  a result is pending in the queue
- `fwd_addr`  out  REG_ADDR_WIDTH  destination of youngest pending entry
- `fwd_data`  out  DATA_WIDTH  data of youngest pending entry
- `overrun`  out  1  sticky: result arrived while `wb_ready` low

## Operation
- Storage: 2-entry circular queue (head ptr, tail ptr, 2-bit count 0..2), entries = {dest, data}.
- Push: `alu_result_valid && wb_ready && !flush` writes entry at tail, tail toggles, count+1.
- Pop: `rf_write_en && rf_write_ready && !flush` advances head, count-1.
- Push and pop same cycle: count unchanged; legal at count 1 (new entry becomes head next cycle). At count 2 push is blocked (`wb_ready`=0) even if a pop occurs.
- `wb_ready` = (count != 2); combinational from registered count only, never from `rf_write_ready`.
- Flags: on push, for each mask bit set, the corresponding flag takes the ALU flag value; cleared mask bits hold. Mask 0 leaves flags unchanged. Flags update at push, not at drain.
- Forwarding: `fwd_valid` = count != 0; `fwd_addr/data` = entry at tail-1. When count 0 the fwd data outputs hold the last written entry (don't-care).
- `rf_write_en` = count != 0; addr/data from head entry; no combinational path from `alu_*` inputs to any output.
- Flush: count, head, tail to 0; same-cycle input discarded including its flag update; flags keep current value; `overrun` unaffected.
- `overrun`: set when `alu_result_valid && !wb_ready && !flush`; cleared only by reset. Offending result is dropped, flags unchanged.
- Reset (`rst_n` low, any time, mid-drain included): count/ptrs 0, `flags`=4'h0, `overrun`=0, so `wb_ready`=1, `rf_write_en`=0, `fwd_valid`=0; entry storage need not reset (outputs must be 0 while reset asserted: gate addr/data with valid or reset storage, implementer's choice, but `rf_write_addr`/`rf_write_data` read 0 out of reset).

## Timing
- Latency: result pushed at edge N appears on `rf_write_en` and `fwd_*` in cycle N+1; `flags` reflect it in cycle N+1.
- Throughput: 1 result/cycle sustained when `rf_write_ready` held high.
- Back-pressure: two consecutive results with `rf_write_ready` low fill the queue; `wb_ready` drops in the following cycle and rises the cycle after the first pop.
- Reset deassertion synchronous use: first push permitted on first rising edge after `rst_n` high.

## Test plan
- Reset then push result 0x0000_0005, dest 3, mask 4'hF, flags Z=0 N=0 V=0 C=1 with `rf_write_ready`=1 -> next cycle `rf_write_en`=1, addr 3, data 5, `flags`=4'b0001; cycle after, `rf_write_en`=0.
- `rf_write_ready`=0, push 0x11 (dest 1) then 0x22 (dest 2) -> count 2, `wb_ready`=0, `fwd_addr`=2/`fwd_data`=0x22; raise ready -> writes 0x11 then 0x22 in consecutive cycles, `wb_ready` returns 1 after first pop.
- Queue full, assert `alu_result_valid` with 0x33 -> `overrun`=1 sticky, 0x33 never written, flags unchanged.
- Flags set to 4'b1111, push with mask 4'b0100 and N=0 -> `flags`=4'b1011; push with mask 0 -> flags unchanged.
- Queue holding 2 entries, `flush` with simultaneous valid result mask 4'hF -> next cycle count 0, `rf_write_en`=0, flags unchanged.
- Assert `rst_n` low mid-drain with 2 entries -> immediately `rf_write_en`=0, `wb_ready`=1, `flags`=0, `overrun`=0.

Source files
------------

// File: rtl/w0rm_core_alu_writeback.sv
// ---------------------------------------------------------------------------
// w0rm_core_alu_writeback
// ALU writeback stage: captures valid ALU results into a 2-entry in-order
// queue, updates the architectural flag register at capture time, and drains
// results to the register-file write port under back-pressure.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   flush                   drop queued writes and the same-cycle input
//   alu_result_valid/...    ALU result, flags, destination and flag mask
//   wb_ready                stage can accept a result this cycle
//   rf_write_en/addr/data   queue head towards the register file
//   rf_write_ready          register file accepts the head this cycle
//   flags                   architectural flags {Z,N,V,C}
//   fwd_valid/addr/data     youngest pending entry for operand forwarding
//   overrun                 sticky: result arrived while wb_ready was low
// ---------------------------------------------------------------------------
module w0rm_core_alu_writeback #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      alu_result_valid,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic                      alu_flag_zero,
   input  logic                      alu_flag_negative,
   input  logic                      alu_flag_overflow,
   input  logic                      alu_flag_carry,
   input  logic [REG_ADDR_WIDTH-1:0] alu_dest,
   input  logic [3:0]                alu_flags_mask,
   output logic                      wb_ready,
   output logic                      rf_write_en,
   output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_data,
   input  logic                      rf_write_ready,
   output logic [3:0]                flags,
   output logic                      fwd_valid,
   output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
   output logic [DATA_WIDTH-1:0]     fwd_data,
   output logic                      overrun
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   logic [CNT_W-1:0]          count_q, count_d;
   logic                      head_q, head_d;
   logic                      tail_q, tail_d;
   logic [3:0]                flags_q, flags_d;
   logic                      overrun_q, overrun_d;
   logic [DATA_WIDTH-1:0]     data_q [DEPTH];
   logic [REG_ADDR_WIDTH-1:0] dest_q [DEPTH];
   logic                      push;
   logic                      pop;
   logic [3:0]                alu_flags;

   // Outputs decode registered state only; no path from alu_* inputs.
   assign wb_ready      = (count_q != CNT_W'(DEPTH));
   assign rf_write_en   = (count_q != '0);
   assign rf_write_addr = dest_q[head_q];
   assign rf_write_data = data_q[head_q];
   assign fwd_valid     = (count_q != '0);
   // Youngest entry sits one slot behind the tail; with 2 slots that is ~tail.
   assign fwd_addr      = dest_q[~tail_q];
   assign fwd_data      = data_q[~tail_q];
   assign flags         = flags_q;
   assign overrun       = overrun_q;

   assign alu_flags = {alu_flag_zero, alu_flag_negative, alu_flag_overflow, alu_flag_carry};
   assign push      = alu_result_valid && wb_ready && !flush;
   assign pop       = rf_write_en && rf_write_ready && !flush;

   // Next-state for queue control, flags and overrun.
   always_comb begin
      count_d   = count_q;
      head_d    = head_q;
      tail_d    = tail_q;
      flags_d   = flags_q;
      overrun_d = overrun_q;

      if (flush) begin
         count_d = '0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (push) tail_d = ~tail_q;
         if (pop)  head_d = ~head_q;
      end

      if (push) flags_d = (flags_q & ~alu_flags_mask) | (alu_flags & alu_flags_mask);

      if (alu_result_valid && !wb_ready && !flush) overrun_d = 1'b1;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         head_q    <= 1'b0;
         tail_q    <= 1'b0;
         flags_q   <= 4'h0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         flags_q   <= flags_d;
         overrun_q <= overrun_d;
      end
   end

   // Entry storage; reset so write/forward buses read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         dest_q[0] <= '0;
         dest_q[1] <= '0;
      end else if (push) begin
         data_q[tail_q] <= alu_result;
         dest_q[tail_q] <= alu_dest;
      end
   end

endmodule

// File: tb/tb_w0rm_core_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_w0rm_core_alu_writeback
// Directed testbench for w0rm_core_alu_writeback with hand-computed
// expectations; one task per scenario.
// ---------------------------------------------------------------------------
module tb_w0rm_core_alu_writeback;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        alu_result_valid;
   logic [31:0] alu_result;
   logic        alu_flag_zero, alu_flag_negative, alu_flag_overflow, alu_flag_carry;
   logic [3:0]  alu_dest;
   logic [3:0]  alu_flags_mask;
   logic        wb_ready;
   logic        rf_write_en;
   logic [3:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        rf_write_ready;
   logic [3:0]  flags;
   logic        fwd_valid;
   logic [3:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   w0rm_core_alu_writeback #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .alu_result_valid  (alu_result_valid),
      .alu_result        (alu_result),
      .alu_flag_zero     (alu_flag_zero),
      .alu_flag_negative (alu_flag_negative),
      .alu_flag_overflow (alu_flag_overflow),
      .alu_flag_carry    (alu_flag_carry),
      .alu_dest          (alu_dest),
      .alu_flags_mask    (alu_flags_mask),
      .wb_ready          (wb_ready),
      .rf_write_en       (rf_write_en),
      .rf_write_addr     (rf_write_addr),
      .rf_write_data     (rf_write_data),
      .rf_write_ready    (rf_write_ready),
      .flags             (flags),
      .fwd_valid         (fwd_valid),
      .fwd_addr          (fwd_addr),
      .fwd_data          (fwd_data),
      .overrun           (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] dst,
                        input logic [3:0] znvc, input logic [3:0] m);
      alu_result_valid  = v;
      alu_result        = d;
      alu_dest          = dst;
      alu_flag_zero     = znvc[3];
      alu_flag_negative = znvc[2];
      alu_flag_overflow = znvc[1];
      alu_flag_carry    = znvc[0];
      alu_flags_mask    = m;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      rf_write_ready = 1'b1;
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      #12;
      checks++;
      if ({wb_ready, rf_write_en, fwd_valid, overrun} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b exp 1000", {wb_ready, rf_write_en, fwd_valid, overrun});
      end
      checks++;
      if (flags !== 4'h0) begin
         errors++;
         $display("FAIL reset_flags: got %h exp 0", flags);
      end
      checks++;
      if ({rf_write_addr, rf_write_data} !== 36'h0) begin
         errors++;
         $display("FAIL reset_wbus: got %h/%h exp 0/0", rf_write_addr, rf_write_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      drive(1'b1, 32'h5, 4'd3, 4'b0001, 4'hF);
      step();
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 4'd3, 32'h5}) begin
         errors++;
         $display("FAIL single_write: got en=%b a=%h d=%h exp en=1 a=3 d=5", rf_write_en, rf_write_addr, rf_write_data);
      end
      checks++;
      if (flags !== 4'b0001) begin
         errors++;
         $display("FAIL single_flags: got %b exp 0001", flags);
      end
      checks++;
      if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 4'd3, 32'h5}) begin
         errors++;
         $display("FAIL single_fwd: got v=%b a=%h d=%h exp 1/3/5", fwd_valid, fwd_addr, fwd_data);
      end
      step();
      checks++;
      if ({rf_write_en, fwd_valid} !== 2'b00) begin
         errors++;
         $display("FAIL single_drain: got en=%b fv=%b exp 0/0", rf_write_en, fwd_valid);
      end
   endtask

   task automatic test_backpressure_overrun();
      rf_write_ready = 1'b0;
      drive(1'b1, 32'h11, 4'd1, 4'h0, 4'h0);
      step();
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_one_ready: got %b exp 1", wb_ready);
      end
      drive(1'b1, 32'h22, 4'd2, 4'h0, 4'h0);
      step();
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if (wb_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_ready: got %b exp 0", wb_ready);
      end
      checks++;
      if ({fwd_addr, fwd_data} !== {4'd2, 32'h22}) begin
         errors++;
         $display("FAIL bp_fwd: got a=%h d=%h exp 2/22", fwd_addr, fwd_data);
      end
      checks++;
      if ({rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 4'd1, 32'h11}) begin
         errors++;
         $display("FAIL bp_head: got en=%b a=%h d=%h exp 1/1/11", rf_write_en, rf_write_addr, rf_write_data);
      end
      // Result while full: dropped, overrun set, flags untouched.
      drive(1'b1, 32'h33, 4'd5, 4'b1110, 4'hF);
      step();
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b exp 1", overrun);
      end
      checks++;
      if (flags !== 4'b0001) begin
         errors++;
         $display("FAIL overrun_flags: got %b exp 0001", flags);
      end
      rf_write_ready = 1'b1;
      step();
      checks++;
      if ({wb_ready, rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 1'b1, 4'd2, 32'h22}) begin
         errors++;
         $display("FAIL bp_second: got r=%b en=%b a=%h d=%h exp 1/1/2/22", wb_ready, rf_write_en, rf_write_addr, rf_write_data);
      end
      step();
      checks++;
      if ({rf_write_en, overrun} !== 2'b01) begin
         errors++;
         $display("FAIL bp_empty: got en=%b ov=%b exp 0/1", rf_write_en, overrun);
      end
   endtask

   task automatic test_flags_throughput();
      rf_write_ready = 1'b1;
      drive(1'b1, 32'hA1, 4'd7, 4'b1111, 4'hF);
      step();
      checks++;
      if ({flags, rf_write_data} !== {4'b1111, 32'hA1}) begin
         errors++;
         $display("FAIL flags_all: got f=%b d=%h exp 1111/a1", flags, rf_write_data);
      end
      drive(1'b1, 32'hA2, 4'd8, 4'b1011, 4'b0100);
      step();
      checks++;
      if ({flags, rf_write_data, wb_ready} !== {4'b1011, 32'hA2, 1'b1}) begin
         errors++;
         $display("FAIL flags_n_only: got f=%b d=%h r=%b exp 1011/a2/1", flags, rf_write_data, wb_ready);
      end
      drive(1'b1, 32'hA3, 4'd9, 4'b0000, 4'b0000);
      step();
      checks++;
      if ({flags, rf_write_addr, rf_write_data} !== {4'b1011, 4'd9, 32'hA3}) begin
         errors++;
         $display("FAIL flags_mask0: got f=%b a=%h d=%h exp 1011/9/a3", flags, rf_write_addr, rf_write_data);
      end
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      step();
      checks++;
      if (rf_write_en !== 1'b0) begin
         errors++;
         $display("FAIL thru_drain: got %b exp 0", rf_write_en);
      end
   endtask

   task automatic test_flush();
      rf_write_ready = 1'b0;
      drive(1'b1, 32'hB1, 4'd1, 4'h0, 4'h0);
      step();
      drive(1'b1, 32'hB2, 4'd2, 4'h0, 4'h0);
      step();
      flush = 1'b1;
      drive(1'b1, 32'hB3, 4'd3, 4'b0100, 4'hF);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({rf_write_en, fwd_valid, wb_ready} !== 3'b001) begin
         errors++;
         $display("FAIL flush_empty: got en=%b fv=%b r=%b exp 0/0/1", rf_write_en, fwd_valid, wb_ready);
      end
      checks++;
      if ({flags, overrun} !== {4'b1011, 1'b1}) begin
         errors++;
         $display("FAIL flush_flags: got f=%b ov=%b exp 1011/1", flags, overrun);
      end
   endtask

   task automatic test_reset_mid_drain();
      rf_write_ready = 1'b0;
      drive(1'b1, 32'hC1, 4'd4, 4'b1111, 4'hF);
      step();
      drive(1'b1, 32'hC2, 4'd5, 4'h0, 4'h0);
      step();
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      rf_write_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wb_ready, rf_write_en, fwd_valid, overrun, flags} !== {4'b1000, 4'h0}) begin
         errors++;
         $display("FAIL rst_mid: got r=%b en=%b fv=%b ov=%b f=%b exp 1/0/0/0/0000", wb_ready, rf_write_en, fwd_valid, overrun, flags);
      end
      checks++;
      if ({rf_write_addr, rf_write_data} !== 36'h0) begin
         errors++;
         $display("FAIL rst_mid_bus: got %h/%h exp 0/0", rf_write_addr, rf_write_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'hD0, 4'd6, 4'b0010, 4'b0010);
      step();
      drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({rf_write_en, rf_write_addr, rf_write_data, flags} !== {1'b1, 4'd6, 32'hD0, 4'b0010}) begin
         errors++;
         $display("FAIL post_rst_push: got en=%b a=%h d=%h f=%b exp 1/6/d0/0010", rf_write_en, rf_write_addr, rf_write_data, flags);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure_overrun();
      test_flags_throughput();
      test_flush();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
